comparator_4bit: RTL and testbench
==================================

COMPARATOR_4BIT -- requirements
Module: comparator_4bit

Interface
REQ-001 Parameters: none; the module SHALL have fixed widths (4-bit input, 3-bit output).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset_n  input  1  asynchronous, active-low reset; assertion SHALL clear all state immediately, independent of clk.
REQ-004 abcd  input  4  operand pair; A = abcd[3:2] (a = MSB), B = abcd[1:0] (c = MSB), both unsigned 2-bit.
REQ-005 xyz  output  3  registered compare result; x = xyz[2] (A>B), y = xyz[1] (A==B), z = xyz[0] (A<B).
REQ-006 Port order SHALL be clk, reset_n, abcd, xyz.

Function
REQ-007 Comparison SHALL be unsigned 2-bit magnitude compare of A against B; no sign extension, no carry beyond bit 1.
REQ-008 x SHALL be 1 iff A>B; y SHALL be 1 iff A==B; z SHALL be 1 iff A<B.
REQ-009 Outside reset and after the first post-reset clock edge, xyz SHALL be exactly one-hot: 100, 010 or 001.
REQ-010 xyz SHALL be driven only from flip-flops; no combinational path from abcd to xyz.
REQ-011 Latency with COMPARATOR_4BIT_SYNC_EN undefined: xyz SHALL reflect the abcd value sampled at edge N from edge N onward (1 cycle).
REQ-012 abcd changes between edges SHALL have no effect on xyz until the next rising edge; glitches not sampled are ignored.
REQ-013 Holding abcd constant SHALL keep xyz constant, with no toggling.
REQ-014 Boundaries: A=B=0 (0000) and A=B=3 (1111) SHALL give 010; A=3,B=0 (1100) SHALL give 100; A=0,B=3 (0011) SHALL give 001.
REQ-015 All 16 abcd codes SHALL be legal; no X or Z output for any defined input.

Reset
REQ-016 While reset_n=0, xyz SHALL be 000, and all internal registers (including synchronizer stages) SHALL be 0.
REQ-017 Reset assertion mid-operation SHALL force xyz to 000 within the same simulation time step, without waiting for clk.
REQ-018 After reset_n deasserts, xyz SHALL stay 000 until the first rising edge. From that edge (plus synchronizer latency, if enabled) it SHALL show the compare result.
REQ-019 Reset release SHALL be sampled by clk like any other input; no other reset sequencing is required.

Configuration
REQ-020 Macro COMPARATOR_4BIT_SYNC_EN: when defined, abcd SHALL pass through a two-stage flip-flop synchronizer before the compare/output register, giving a total latency of 3 rising edges.
REQ-021 When defined, synchronizer stages SHALL reset to 0, so xyz SHALL read 010 once the pipeline fills after reset with abcd=0000.
REQ-022 When COMPARATOR_4BIT_SYNC_EN is undefined, the synchronizer SHALL be absent and latency SHALL be 1 edge (REQ-011).
REQ-023 Compare logic and output mapping SHALL be identical in both builds.

Verification
REQ-024 Exhaustive sweep: clk period 10 ns, reset released, abcd=0..15 each held 10 ns (160 ns total) -> xyz after latency = 010 for 0,5,10,15; 100 for 4,8,9,12,13,14; 001 for 1,2,3,6,7,11.
REQ-025 Reset mid-run: abcd=1100, xyz=100, pull reset_n low between edges -> xyz=000 immediately; release with abcd=0011 -> xyz=001 after the latency.
REQ-026 Latency check: step abcd from 0000 to 0100 just after an edge -> xyz stays 010 until the next edge (3 edges when SYNC_EN is defined), then becomes 100.
REQ-027 Mid-cycle glitch: pulse abcd 0000->0011->0000 entirely between two edges -> xyz stays 010.
REQ-028 One-hot assertion: on every clock edge after the fill period, the check $onehot(xyz) SHALL hold. The bench SHALL run this check in both macro builds.

Source files
------------

// File: rtl/comparator_4bit.sv
// Registered 2-bit unsigned magnitude comparator: A = abcd[3:2], B = abcd[1:0], xyz = {A>B, A==B, A<B}.
// Optional macro COMPARATOR_4BIT_SYNC_EN inserts a two-stage input synchronizer (latency 3 edges instead of 1).
module comparator_4bit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] abcd,
  output logic [2:0] xyz
);

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned OUT_W = 3;

  logic [IN_W-1:0]  cmp_in;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [OUT_W-1:0] xyz_d;
  logic [OUT_W-1:0] xyz_q;

`ifdef COMPARATOR_4BIT_SYNC_EN
  logic [IN_W-1:0] sync1_d;
  logic [IN_W-1:0] sync1_q;
  logic [IN_W-1:0] sync2_d;
  logic [IN_W-1:0] sync2_q;

  // Two-flop synchronizer ahead of the compare register
  always_comb begin
    sync1_d = abcd;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IN_W'(0);
      sync2_q <= IN_W'(0);
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign cmp_in = sync2_q;
`else
  assign cmp_in = abcd;
`endif

  // Unsigned compare; exactly one of the three result bits is set
  always_comb begin
    op_a  = cmp_in[3:2];
    op_b  = cmp_in[1:0];
    xyz_d = OUT_W'(0);
    if (op_a > op_b) begin
      xyz_d = 3'b100;
    end else if (op_a == op_b) begin
      xyz_d = 3'b010;
    end else begin
      xyz_d = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xyz_q <= OUT_W'(0);
    end else begin
      xyz_q <= xyz_d;
    end
  end

  assign xyz = xyz_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit; builds with or without COMPARATOR_4BIT_SYNC_EN.
module tb_comparator_4bit;

`ifdef COMPARATOR_4BIT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] abcd;
  logic [2:0] xyz;

  int total;
  int bad;

  // Samples taken at each post-reset edge, newest first; result shows the one LAT-1 edges old
  logic [3:0] hist[$];
  bit         valid;

  comparator_4bit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .abcd    (abcd),
    .xyz     (xyz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_xyz(input logic [3:0] v);
    int a;
    int b;
    a = int'(v) / 4;
    b = int'(v) % 4;
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Expected results listed literally for the exhaustive sweep
  function automatic logic [2:0] sweep_exp(input int v);
    case (v)
      0, 5, 10, 15:           return 3'b010;
      4, 8, 9, 12, 13, 14:    return 3'b100;
      default:                return 3'b001;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < LAT; i++) hist.push_back(4'd0);
    valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      hist.push_front(abcd);
      void'(hist.pop_back());
      valid = 1'b1;
    end
    #1;
    check_eq("model", xyz, valid ? ref_xyz(hist[LAT-1]) : 3'b000);
    if (valid) check_eq("onehot", {2'b00, $onehot(xyz)}, 3'b001);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    abcd    = 4'b0000;
    model_reset();

    #3;
    check_eq("reset_idle", xyz, 3'b000);
    abcd = 4'b1100;
    tick();
    tick();
    check_eq("reset_hold", xyz, 3'b000);

    // Release between edges; output must wait for the next edge
    abcd = 4'b0000;
    #3;
    reset_n = 1'b1;
    #1;
    check_eq("post_release", xyz, 3'b000);

    // Exhaustive sweep, each code held for the full latency
    for (int v = 0; v < 16; v++) begin
      abcd = 4'(v);
      for (int k = 0; k < LAT; k++) tick();
      check_eq($sformatf("sweep_%0d", v), xyz, sweep_exp(v));
    end

    // Boundaries
    abcd = 4'b0000; for (int k = 0; k < LAT; k++) tick(); check_eq("bnd_0000", xyz, 3'b010);
    abcd = 4'b1111; for (int k = 0; k < LAT; k++) tick(); check_eq("bnd_1111", xyz, 3'b010);
    abcd = 4'b1100; for (int k = 0; k < LAT; k++) tick(); check_eq("bnd_1100", xyz, 3'b100);
    abcd = 4'b0011; for (int k = 0; k < LAT; k++) tick(); check_eq("bnd_0011", xyz, 3'b001);

    // Latency step 0000 -> 0100
    abcd = 4'b0000;
    for (int k = 0; k < LAT; k++) tick();
    abcd = 4'b0100;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) check_eq("lat_hold", xyz, 3'b010);
      else         check_eq("lat_step", xyz, 3'b100);
    end

    // Glitch entirely between two edges
    abcd = 4'b0000;
    for (int k = 0; k < LAT; k++) tick();
    #2;
    abcd = 4'b0011;
    #2;
    abcd = 4'b0000;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      check_eq("glitch", xyz, 3'b010);
    end

    // Constant input holds output steady
    abcd = 4'b1001;
    for (int k = 0; k < LAT; k++) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("hold_const", xyz, 3'b100);
    end

    // Reset asserted mid-operation, then released with a new operand
    abcd = 4'b1100;
    for (int k = 0; k < LAT; k++) tick();
    check_eq("pre_midreset", xyz, 3'b100);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("midreset_async", xyz, 3'b000);
    abcd = 4'b0011;
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("midreset_release", xyz, 3'b000);
    for (int k = 0; k < LAT; k++) tick();
    check_eq("midreset_result", xyz, 3'b001);

    // Random operands with mid-cycle glitches
    for (int n = 0; n < 300; n++) begin
      abcd = 4'($urandom_range(15));
      #3;
      abcd = 4'($urandom_range(15));
      tick();
    end

    // Random operands with occasional asynchronous resets
    for (int n = 0; n < 200; n++) begin
      abcd = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rand_reset", xyz, 3'b000);
        #2;
        reset_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
